// File: rtl/mult_pkg.sv
// Shared constants for the sequential MULTU path; also used by the ID-stage decode.
package mult_pkg;
  localparam int N_ITER = 32;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mult_seq_ctrl_if.sv
// Operand/result handshake bundle between the ID/EX latch, the multiplier and HI/LO write-back.
interface mult_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output in_valid, mcand, mplier, kill, out_ready,
    input  in_ready, out_valid, busy, hi, lo
  );

  modport slave (
    input  in_valid, mcand, mplier, kill, out_ready,
    output in_ready, out_valid, busy, hi, lo
  );
endinterface

// File: rtl/mult_seq_ctrl_adder_32.sv
// 32-bit combinational ripple adder, sum only; carry-out is deliberately not exported.
module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z
);
  logic [31:0] cy;

  assign cy[0] = 1'b0;

  genvar i;
  generate
    for (i = 0; i < 32; i++) begin : g_bit
      assign z[i] = a[i] ^ b[i] ^ cy[i];
      if (i < 31) begin : g_cy
        assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
      end
    end
  endgenerate
endmodule

// File: rtl/mult_seq_ctrl.sv
// Iterative 32x32 unsigned shift-add multiplier (MULTU) producing HI/LO over 32 cycles.
module mult_seq_ctrl
  import mult_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  mult_seq_ctrl_if.slave  bus
);
  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        mc_r, hi_r, lo_r;
  logic [31:0]        add_b, sum;
  logic               carry;
  logic               load, step;

  adder_32 u_add (
    .a (hi_r),
    .b (add_b),
    .z (sum)
  );

  assign add_b = lo_r[0] ? mc_r : '0;
  // Adder drops carry-out; recover it from the operand and sum MSBs.
  assign carry = (hi_r[31] & add_b[31]) | ((hi_r[31] | add_b[31]) & ~sum[31]);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    case (state)
      S_IDLE: if (bus.in_valid) begin
        load     = 1'b1;
        state_nx = S_RUN;
      end
      S_RUN: begin
        step = 1'b1;
        if (cnt == CNT_W'(N_ITER - 1)) state_nx = S_DONE;
      end
      S_DONE: if (bus.out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (bus.kill) begin
      state_nx = S_IDLE;
      load     = 1'b0;
      step     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mc_r <= '0;
      hi_r <= '0;
      lo_r <= '0;
      cnt  <= '0;
    end else if (load) begin
      mc_r <= bus.mcand;
      hi_r <= '0;
      lo_r <= bus.mplier;
      cnt  <= '0;
    end else if (step) begin
      hi_r <= {carry, sum[31:1]};
      lo_r <= {sum[0], lo_r[31:1]};
      cnt  <= cnt + CNT_W'(1);
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state == S_RUN);
  assign bus.out_valid = (state == S_DONE);
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;
endmodule

// File: doc/mult_seq_ctrl.md
# mult_seq_ctrl

Iterative unsigned multiplier controller for the MIPS CPU execute stage. It implements MULTU by sequencing a single `adder_32` instance through 32 shift-add iterations and producing a 64-bit HI/LO result. The block sits beside the ALU, takes operands from the ID/EX latch, and returns HI/LO to the HI/LO register write path. A valid/ready handshake on both sides lets the pipeline stall on it.

## Interface
- `N_ITER`, 32, number of shift-add iterations; equals the operand width and is fixed for this design.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands are present this cycle.
- `in_ready`  out  1  block can accept operands; high only in IDLE.
- `mcand`  in  32  multiplicand, unsigned.
- `mplier`  in  32  multiplier, unsigned.
- `kill`  in  1  pipeline flush; abandons any operation in progress.
- `out_valid`  out  1  `hi`/`lo` hold a finished product.
- `out_ready`  in  1  consumer takes the result this cycle.
- `busy`  out  1  high in RUN.
- `hi`  out  32  upper product word.
- `lo`  out  32  lower product word.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && !kill`: load `mc_r`←`mcand`, `hi`←0, `lo`←`mplier`, `cnt`←0, then go to RUN.
- RUN, one iteration per cycle:
  - Adder inputs: a=`hi`, b=`lo[0]` ? `mc_r` : 0.
  - Carry-out is not available from `adder_32`, so the block reconstructs it: c = (a[31]&b[31]) | ((a[31]|b[31]) & ~z[31]).
  - Update `hi`←{c, z[31:1]} and `lo`←{z[0], lo[31:1]}.
  - `cnt`←`cnt`+1. When `cnt`==`N_ITER`-1, go to DONE after this update.
- DONE:
  - `out_valid`=1. `hi` and `lo` stay stable until the result is taken.
  - On `out_ready`, go to IDLE.
- `kill` overrides all other inputs:
  - In any state, `kill` sends the block to IDLE next cycle.
  - `hi`/`lo` keep whatever values they hold; they are don't-care because `out_valid` is low.
  - `kill` and `in_valid` in the same cycle in IDLE: no accept.
- `rst` overrides `kill`.
- Arithmetic:
  - `cnt` is 5 bits, wraps 31→0 on the final iteration, and is not read outside RUN.
  - The product is exact for all 2^64 operand pairs; there is no overflow.
- `in_ready` is low in DONE, so a new operation cannot be accepted in the cycle the result is consumed.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `busy`=0, `hi`=0, `lo`=0, state=IDLE, `cnt`=0.
- Accept edge is T0. RUN spans cycles T0+1 … T0+32. `out_valid` rises at T0+33.
- Latency from accept to `out_valid` is 33 cycles. The minimum period between accepts is 34 cycles, with `out_ready` held high.
- `out_valid` and `hi`/`lo` remain stable while `out_ready`=0, with no upper bound.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- The adder is purely combinational. Its ripple path, plus the carry reconstruction, plus the `hi` mux, must close in one cycle.
- `rst` asserted mid-RUN: at the next edge the block is in reset state and the partial product is discarded.

## Structure
- Shared package/header `mult_pkg`:
  - State encoding constants S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2.
  - `N_ITER`=32 and `CNT_W`=5.
  - The ID-stage decode that raises `in_valid` uses the same package.
- Sub-module: exactly one `adder_32` instance for the datapath adder. Do not use an inline `+`.
- The carry reconstruction, shift registers, counter and FSM all live in `mult_seq_ctrl` itself.

## Test plan
- mcand=3, mplier=5, accept at T0 → `out_valid` at T0+33 with `hi`=0x00000000, `lo`=0x0000000F. `busy` is high for exactly 32 cycles.
- mcand=0xFFFFFFFF, mplier=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. This exercises carry reconstruction on every iteration.
- mcand=0x80000000, mplier=0x00000002, with `out_ready` held low for 10 cycles after `out_valid` → `hi`=0x00000001, `lo`=0 stay stable throughout. The block returns to IDLE one cycle after `out_ready`.
- `kill` asserted at T0+12 → IDLE at T0+13 and `out_valid` never rises. A follow-on mcand=7, mplier=6 accepted at T0+13 gives `lo`=0x2A at T0+46.
- `rst` asserted at T0+20 of a 0x12345678×0x9ABCDEF0 operation → all outputs at reset values next cycle. A rerun without reset gives `hi`=0x0B00EA4E, `lo`=0x242D2080.
- `in_valid` and `kill` in the same IDLE cycle → no accept, and `busy` stays 0.
